bcd2bin_seq: RTL and testbench

- Sequential BCD-to-binary converter, the inverse of the display-path binary-to-BCD conversion.
- Accepts a sign nibble plus `digits` BCD digits, entered from switches or a keypad front end.
- Produces a signed two's-complement value of `width` bits for the ALU operand path.
- Uses iterative reverse double-dabble (shift right, subtract-3 correction): one bit per clock, fixed latency, start/done handshake.

---
 rtl/bcd2bin_seq.sv | 192 +++++++++++++++++++
 tb/tb_bcd2bin_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq
//   Sequential BCD-to-binary converter (reverse double-dabble), one bit per
//   clock, fixed latency. Takes a sign nibble plus `digits` BCD digits and
//   produces a saturated signed two's-complement value of `width` bits.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request conversion, sampled only in IDLE
//   bcd      in   BCD magnitude, most significant digit in top nibble
//   bcd_sgn  in   sign nibble, 4'hA = negative, anything else = positive
//   busy     out  conversion in progress (start edge through the done cycle)
//   done     out  one-cycle pulse when bin/err are updated
//   bin      out  signed result, held until the next done
//   err      out  range or digit error for the current result
// ---------------------------------------------------------------------------
module bcd2bin_seq #(
  parameter int unsigned width  = 12,
  parameter int unsigned digits = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*digits-1:0]   bcd,
  input  logic [3:0]            bcd_sgn,
  output logic                  busy,
  output logic                  done,
  output logic [width-1:0]      bin,
  output logic                  err
);

  localparam int unsigned ACC_W = 4 * digits;
  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  // Comparison width wide enough for both the magnitude and the range limits.
  localparam int unsigned CMP_W = ((width > ACC_W) ? width : ACC_W) + 1;

  localparam logic [CMP_W-1:0] POS_LIMIT   = (CMP_W'(1) << (width - 1)) - CMP_W'(1);
  localparam logic [CMP_W-1:0] NEG_LIMIT   = CMP_W'(1) << (width - 1);
  localparam logic [width-1:0] BIN_POS_SAT = {1'b0, {(width - 1){1'b1}}};
  localparam logic [width-1:0] BIN_NEG_SAT = {1'b1, {(width - 1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(ACC_W);
  localparam logic [3:0]       SGN_NEG     = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               bad_q, bad_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [width-1:0]   bin_q, bin_d;
  logic               err_q, err_d;

  logic               digit_bad_c;
  logic [ACC_W-1:0]   bcd_sh_c;
  logic [ACC_W-1:0]   bcd_fix_c;
  logic [ACC_W-1:0]   acc_sh_c;
  logic [CMP_W-1:0]   mag_c;
  logic [width-1:0]   res_bin_c;
  logic               res_err_c;

  // Flag any input nibble outside 0..9.
  always_comb begin
    digit_bad_c = 1'b0;
    for (int i = 0; i < int'(digits); i++) begin
      if (bcd[4*i +: 4] > 4'd9) begin
        digit_bad_c = 1'b1;
      end
    end
  end

  // One reverse double-dabble step: shift {bcd, acc} right, then correct
  // every BCD nibble that picked up a carried-in 8 (should have been 5).
  always_comb begin
    bcd_sh_c  = {1'b0, bcd_q[ACC_W-1:1]};
    acc_sh_c  = {bcd_q[0], acc_q[ACC_W-1:1]};
    bcd_fix_c = bcd_sh_c;
    for (int i = 0; i < int'(digits); i++) begin
      if (bcd_sh_c[4*i +: 4] >= 4'd8) begin
        bcd_fix_c[4*i +: 4] = bcd_sh_c[4*i +: 4] - 4'd3;
      end
    end
  end

  // Signed result with saturation, from the finished magnitude.
  always_comb begin
    mag_c     = CMP_W'(acc_q);
    res_bin_c = '0;
    res_err_c = 1'b0;
    if (bad_q) begin
      res_bin_c = '0;
      res_err_c = 1'b1;
    end else if (!neg_q && (mag_c > POS_LIMIT)) begin
      res_bin_c = BIN_POS_SAT;
      res_err_c = 1'b1;
    end else if (neg_q && (mag_c > NEG_LIMIT)) begin
      res_bin_c = BIN_NEG_SAT;
      res_err_c = 1'b1;
    end else if (neg_q) begin
      res_bin_c = width'(CMP_W'(0) - mag_c);
    end else begin
      res_bin_c = width'(mag_c);
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    bad_d   = bad_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bcd_d   = bcd;
          acc_d   = '0;
          neg_d   = (bcd_sgn == SGN_NEG);
          bad_d   = digit_bad_c;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_fix_c;
        acc_d = acc_sh_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        bin_d   = res_bin_c;
        err_d   = res_err_c;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy also covers the cycle in which done is high.
    busy_d = (state_d != ST_IDLE) || (state_q == ST_FINISH);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = bin_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd2bin_seq
//   Scoreboard bench for bcd2bin_seq: stimulus pushes hand-computed results,
//   a monitor pops and compares on every done pulse (value, error, latency).
// ---------------------------------------------------------------------------
module tb_bcd2bin_seq;

  localparam int unsigned W = 12;
  localparam int unsigned D = 4;
  localparam int unsigned LAT = 17;

  typedef struct packed {
    logic [W-1:0] bin;
    logic         err;
    int unsigned  edge_n;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [4*D-1:0] bcd;
  logic [3:0]     bcd_sgn;
  logic           busy;
  logic           done;
  logic [W-1:0]   bin;
  logic           err;

  int          checks   = 0;
  int          failures = 0;
  int unsigned edge_cnt = 0;
  exp_t        sb[$];

  bcd2bin_seq #(.width(W), .digits(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd     (bcd),
    .bcd_sgn (bcd_sgn),
    .busy    (busy),
    .done    (done),
    .bin     (bin),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(bin), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bin", 32'(bin), 32'(e.bin));
        chk("err", 32'(err), 32'(e.err));
        chk("done_edge", edge_cnt, e.edge_n);
      end
    end
  end

  // Issue a one-cycle start; the edge it lands on is edge_cnt+1.
  task automatic issue(input logic [4*D-1:0] b, input logic [3:0] s,
                       input logic [W-1:0] eb, input logic ee);
    exp_t e;
    @(negedge clk);
    bcd     = b;
    bcd_sgn = s;
    start   = 1'b1;
    e.bin    = eb;
    e.err    = ee;
    e.edge_n = edge_cnt + 1 + LAT;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic conv(input logic [4*D-1:0] b, input logic [3:0] s,
                      input logic [W-1:0] eb, input logic ee);
    issue(b, s, eb, ee);
    wait_idle();
  endtask

  initial begin
    int busy_cycles;
    exp_t e;
    rst_n   = 1'b0;
    start   = 1'b0;
    bcd     = '0;
    bcd_sgn = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bin",  32'(bin),  0);
    chk("rst_err",  32'(err),  0);
    rst_n = 1'b1;
    @(negedge clk);

    // First conversion: also count busy cycles.
    issue(16'h1234, 4'hF, 12'h4D2, 1'b0);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
    end
    chk("busy_cycles", busy_cycles, 18);
    wait_idle();

    conv(16'h2048, 4'hA, 12'h800, 1'b0);
    conv(16'h2048, 4'hF, 12'h7FF, 1'b1);
    conv(16'h2047, 4'hB, 12'h7FF, 1'b0);
    conv(16'h2049, 4'hA, 12'h800, 1'b1);
    conv(16'h9999, 4'hA, 12'h800, 1'b1);
    conv(16'h12C4, 4'hF, 12'h000, 1'b1);
    conv(16'h0000, 4'hA, 12'h000, 1'b0);
    conv(16'h0999, 4'hA, 12'hC19, 1'b0);
    conv(16'h0001, 4'hA, 12'hFFF, 1'b0);
    conv(16'h0000, 4'h0, 12'h000, 1'b0);

    // start while busy is ignored; bcd changes mid-flight have no effect.
    issue(16'h0005, 4'hF, 12'h005, 1'b0);
    repeat (4) @(negedge clk);
    bcd   = 16'h0007;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (25) @(negedge clk);

    // start held high: back-to-back conversions every 18 cycles.
    @(negedge clk);
    bcd     = 16'h0100;
    bcd_sgn = 4'hF;
    start   = 1'b1;
    e.bin = 12'h064; e.err = 1'b0; e.edge_n = edge_cnt + 1 + LAT;
    sb.push_back(e);
    e.bin = 12'h0C8; e.err = 1'b0; e.edge_n = edge_cnt + 1 + LAT + 18;
    sb.push_back(e);
    @(negedge clk);
    bcd = 16'h0200;
    repeat (18) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-conversion: outputs clear at once, no done afterwards.
    @(negedge clk);
    bcd     = 16'h0321;
    bcd_sgn = 4'hF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_bin",  32'(bin),  0);
    chk("midrst_err",  32'(err),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    conv(16'h0321, 4'hF, 12'h141, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", edge_cnt);
    $fatal(1, "timeout");
  end

endmodule
